// File: rtl/slc3_io_pkg.sv
// Shared constants and event payload for the SLC-3 board I/O conditioning blocks.
package slc3_io_pkg;

    localparam int unsigned SIM_DEBOUNCE_CYCLES   = 4;
    localparam int unsigned BOARD_DEBOUNCE_CYCLES = 500000;
    localparam bit          DEFAULT_ACTIVE_LOW    = 1'b1;

    // Per-channel event bundle; rel marks an accepted release.
    typedef struct packed {
        logic pressed;
        logic press;
        logic rel;
        logic rpt;
    } btn_evt_t;

    // Pin level seen while the button is not pressed.
    function automatic logic released_level(input bit active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/slc3_debounce_ch.sv
// One button channel: synchroniser, counter debouncer, press/release edge pulses
// and optional auto-repeat while held.
module slc3_debounce_ch
    import slc3_io_pkg::*;
#(
    parameter bit          ACTIVE_LOW      = DEFAULT_ACTIVE_LOW,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = SIM_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = 8
) (
    input  logic     Clk,
    input  logic     Reset_n,
    input  logic     btn_raw,
    output btn_evt_t evt,
    output logic     stable_nxt_c
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          IDLE_LVL = released_level(ACTIVE_LOW);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   stable_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   sample;
    logic                   mismatch;
    logic                   toggle;
    logic                   press_q;
    logic                   rel_q;
    logic                   rpt_w;

    // Metastability chain, loaded with the idle pin level on reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= {SYNC_STAGES{IDLE_LVL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign sample = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

    // Debounce next-state: any agreeing sample restarts the count.
    always_comb begin
        mismatch     = (sample != stable_q);
        toggle       = mismatch && (cnt_q == CNT_LAST);
        cnt_d        = '0;
        if (mismatch && !toggle) begin
            cnt_d = cnt_q + CW'(1);
        end
        stable_nxt_c = stable_q ^ toggle;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            stable_q <= stable_nxt_c;
            cnt_q    <= cnt_d;
            press_q  <= toggle && !stable_q;
            rel_q    <= toggle && stable_q;
        end
    end

    if (REPEAT_CYCLES > 0) begin : g_rpt
        localparam int unsigned   RW        = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
        localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_CYCLES - 1);

        logic [RW-1:0] rcnt_q;
        logic [RW-1:0] rcnt_d;
        logic          rpt_d;
        logic          rpt_q;

        // Count only while held and not on a toggling edge, so press and
        // release both leave the counter at zero with no pulse.
        always_comb begin
            rcnt_d = '0;
            rpt_d  = 1'b0;
            if (stable_q && !toggle) begin
                if (rcnt_q == RCNT_LAST) begin
                    rpt_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
        end

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                rcnt_q <= '0;
                rpt_q  <= 1'b0;
            end else begin
                rcnt_q <= rcnt_d;
                rpt_q  <= rpt_d;
            end
        end

        assign rpt_w = rpt_q;
    end else begin : g_no_rpt
        assign rpt_w = 1'b0;
    end

    assign evt.pressed = stable_q;
    assign evt.press   = press_q;
    assign evt.rel     = rel_q;
    assign evt.rpt     = rpt_w;

endmodule

// File: rtl/slc3_button_conditioner.sv
// N-channel push-button conditioner producing clean level and single-cycle
// press/release/repeat events for the SLC-3 control logic.
module slc3_button_conditioner
    import slc3_io_pkg::*;
#(
    parameter int unsigned N_BTN           = 2,
    parameter bit          ACTIVE_LOW      = DEFAULT_ACTIVE_LOW,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = SIM_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] pressed_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] repeat_o,
    output logic             any_pressed_o
);

    btn_evt_t         evt [N_BTN];
    logic [N_BTN-1:0] stable_nxt;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        slc3_debounce_ch #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .Clk          (Clk),
            .Reset_n      (Reset_n),
            .btn_raw      (btn_raw[i]),
            .evt          (evt[i]),
            .stable_nxt_c (stable_nxt[i])
        );

        assign pressed_o[i] = evt[i].pressed;
        assign press_o[i]   = evt[i].press;
        assign release_o[i] = evt[i].rel;
        assign repeat_o[i]  = evt[i].rpt;
    end

    // Registered from next-state levels so it tracks pressed_o in the same cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            any_pressed_o <= 1'b0;
        end else begin
            any_pressed_o <= |stable_nxt;
        end
    end

endmodule

// File: doc/slc3_button_conditioner.md
Name: slc3_button_conditioner

Overview:
- Parametrised conditioner for N mechanical push-buttons on the SLC-3 board, e.g. Run and Continue.
- Per channel: metastability synchroniser, counter-based debouncer, edge detection and optional auto-repeat.
- Sits between the board pins and the SLC-3 top-level control logic.
- Replaces raw asynchronous Run/Continue sampling with clean, single-cycle press/release/repeat events.

Parameters:
- N_BTN, 2, number of button channels.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- DEBOUNCE_CYCLES, 4, consecutive mismatching samples needed to accept a new level (>=1); board build overrides with ~500000.
- REPEAT_CYCLES, 8, auto-repeat period while held; 0 disables repeat.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- btn_raw  in  N_BTN  raw pin levels, asynchronous to Clk.
- pressed_o  out  N_BTN  debounced level, active-high = pressed.
- press_o  out  N_BTN  one-cycle pulse on accepted press.
- release_o  out  N_BTN  one-cycle pulse on accepted release.
- repeat_o  out  N_BTN  one-cycle pulse every REPEAT_CYCLES while held.
- any_pressed_o  out  1  OR of pressed_o.

Behaviour:
- Clock and reset: one clock (Clk); reset is asynchronous and active-low (Reset_n).
- Reset values:
  - Synchroniser flops load the released pin level (1 if ACTIVE_LOW, else 0).
  - Stable level = released; debounce and repeat counters = 0.
  - All outputs = 0.
- Polarity: normalise after the last sync stage, so internal pressed = sync_q XOR ACTIVE_LOW.
- Debounce, per channel and independent:
  - On each edge where normalised sync_q != stable, cnt increments.
  - When cnt == DEBOUNCE_CYCLES-1 with a mismatch: stable toggles and cnt clears in the same edge.
  - Any edge with sync_q == stable clears cnt, so bounces restart the count.
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
- Latency:
  - Pin change set up before edge 1 reaches sync_q at edge SYNC_STAGES.
  - stable/pressed_o update at edge SYNC_STAGES+DEBOUNCE_CYCLES; defaults give 6 edges.
- Pulses:
  - press_o / release_o are registered, high for exactly the one cycle following the toggling edge.
  - They never assert together on one channel.
- Auto-repeat (REPEAT_CYCLES>0):
  - rcnt clears on press and counts while pressed.
  - repeat_o pulses when rcnt reaches REPEAT_CYCLES-1, i.e. REPEAT_CYCLES cycles after press_o, then every REPEAT_CYCLES cycles; rcnt wraps to 0 on each pulse.
  - Release clears rcnt immediately; no repeat pulse in or after the release cycle.
  - REPEAT_CYCLES==0: repeat_o tied 0, no repeat counter instantiated.
- Simultaneous events: channels are fully independent; multiple press_o bits may assert in one cycle.
- Reset mid-operation:
  - All state returns to released immediately, with no release_o pulse.
  - A button still held after Reset_n deasserts produces a fresh press_o after the full latency.
- Glitch shorter than DEBOUNCE_CYCLES: no change on any output.

Decomposition:
- Package slc3_io_pkg:
  - Constants SIM_DEBOUNCE_CYCLES=4 and BOARD_DEBOUNCE_CYCLES=500000.
  - DEFAULT_ACTIVE_LOW=1.
  - Typedef btn_evt_t struct {pressed, press, release, rpt}.
- Sub-module slc3_debounce_ch: one channel (sync, debounce, edge, repeat).
- Top instantiates N_BTN copies in a generate loop and ORs any_pressed_o.

Test Plan (defaults: N_BTN=2, ACTIVE_LOW=1, S=2, D=4, R=8):
- Reset_n low, btn_raw=2'b11 → all outputs 0. Release reset → outputs stay 0 for 20 cycles.
- btn_raw[0] 1→0 before edge 1, held → pressed_o[0]=1 and press_o[0]=1 after edge 6. press_o[0]=0 after edge 7. Channel 1 unchanged.
- Glitch btn_raw[1]=0 for 3 cycles then back to 1 → no output change. Repeat with 4 cycles → press_o[1] pulses.
- Hold channel 0 for 30 cycles after press → repeat_o[0] pulses at 8, 16 and 24 cycles after press_o. Release → release_o[0] one cycle after the 6-cycle latency, no further repeat_o.
- Both buttons pressed in the same cycle → press_o=2'b11 in one cycle; any_pressed_o=1 until both are released.
- Assert Reset_n mid-hold → outputs 0 asynchronously, no release_o. Deassert with button still held → press_o after 6 edges.
